pam4_tx: RTL and testbench

PAM4 baud-rate transmitter producing signed 8-bit line levels at a programmable symbol rate. It serves as the stimulus and loopback source for the baud-rate PAM4 CDR receiver. Each enable sequence opens with a max-transition-density preamble so the CDR can lock. The payload that follows is user bytes (valid/ready), PRBS7, a fixed clock pattern, or mid-level idle, all Gray-mapped onto four levels.

---
 rtl/pam4_pkg.sv | 37 +++
 rtl/pam4_prbs7.sv | 28 ++
 rtl/pam4_tx.sv | 176 +++++++++++++++++
 tb/tb_pam4_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_pkg.sv
// Shared PAM4 transmitter types: line levels, Gray symbol map, FSM states, payload mode codes
// and the PRBS7 (x^7+x^6+1) seed and tap positions.
package pam4_pkg;

  localparam logic signed [7:0] LVL_P96  = 8'sd96;
  localparam logic signed [7:0] LVL_P32  = 8'sd32;
  localparam logic signed [7:0] LVL_N32  = -8'sd32;
  localparam logic signed [7:0] LVL_N96  = -8'sd96;
  localparam logic signed [7:0] LVL_ZERO = 8'sd0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_USER = 2'd0,
    MODE_PRBS = 2'd1,
    MODE_CLK  = 2'd2,
    MODE_IDLE = 2'd3
  } mode_e;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  function automatic logic signed [7:0] gray_level(input logic [1:0] s);
    case (s)
      2'b00:   return LVL_N96;
      2'b01:   return LVL_N32;
      2'b11:   return LVL_P32;
      default: return LVL_P96;
    endcase
  endfunction

endpackage

// File: rtl/pam4_prbs7.sv
// PRBS7 LFSR that advances two steps per enabled cycle; sym is the pair those two steps produce,
// first bit in sym[1]. Combinational output, state updates on the next edge.
module pam4_prbs7
  import pam4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step2,
  output logic [1:0] sym
);

  logic [6:0] lfsr_q, lfsr_d;
  logic       n1, n2;

  always_comb begin
    // second step taps are the first step's taps shifted down one place
    n1     = lfsr_q[PRBS7_TAP_A] ^ lfsr_q[PRBS7_TAP_B];
    n2     = lfsr_q[PRBS7_TAP_A - 1] ^ lfsr_q[PRBS7_TAP_B - 1];
    sym    = {n1, n2};
    lfsr_d = step2 ? {lfsr_q[4:0], n1, n2} : lfsr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= PRBS7_SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/pam4_tx.sv
// PAM4 transmitter: preamble then user/PRBS7/clock/idle payload, registered level/sym/strobe once per
// baud period; s_ready is combinational. PRBS7 source present only when PAM4_TX_PRBS_EN is defined.
module pam4_tx
  import pam4_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int PREAMBLE_LEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIV_W-1:0]        baud_div,
  input  logic [1:0]              mode,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [7:0]       tx_level,
  output logic [1:0]              sym,
  output logic                    sym_stb,
  output logic                    busy,
  output logic                    underrun
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              phase_q, phase_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_vld_q, buf_vld_d;
  logic              underrun_q, underrun_d;
  logic signed [7:0] level_q, level_d;
  logic [1:0]        sym_q, sym_d;
  logic              stb_q, stb_d;
  logic              stb, load, accept, live;
  mode_e             mode_s;

  assign mode_s  = mode_e'(mode);
  assign stb     = en && (cnt_q >= baud_div);
  assign load    = stb && (state_q == ST_PAYLOAD) && (mode_s == MODE_USER) && (idx_q == 2'd0) && buf_vld_q;
  // the buffer frees up in the same cycle it is moved into the shifter
  assign s_ready = en && !rst && (!buf_vld_q || load);
  assign accept  = s_valid && s_ready;

`ifdef PAM4_TX_PRBS_EN
  logic       prbs_step;
  logic [1:0] prbs_sym;

  assign prbs_step = stb && (state_q == ST_PAYLOAD) && (mode_s == MODE_PRBS);

  pam4_prbs7 u_prbs7 (
    .clk   (clk),
    .rst   (rst),
    .step2 (prbs_step),
    .sym   (prbs_sym)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    underrun_d = underrun_q;
    level_d    = level_q;
    sym_d      = sym_q;
    stb_d      = 1'b0;
    live       = 1'b0;
    if (!en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      pre_d     = '0;
      phase_d   = 1'b0;
      idx_d     = 2'd0;
      sh_d      = 8'd0;
      buf_d     = 8'd0;
      buf_vld_d = 1'b0;
      level_d   = LVL_ZERO;
      sym_d     = 2'b00;
    end else begin
      cnt_d = stb ? '0 : cnt_q + 1'b1;
      stb_d = stb;
      if (stb) begin
        if (state_q != ST_PAYLOAD) begin
          sym_d   = phase_q ? 2'b00 : 2'b10;
          live    = 1'b1;
          phase_d = ~phase_q;
          pre_d   = pre_q + 1'b1;
          state_d = (pre_q == PRE_W'(PREAMBLE_LEN - 1)) ? ST_PAYLOAD : ST_PREAMBLE;
        end else begin
          sym_d = 2'b00;
          idx_d = 2'd0;
          case (mode_s)
            MODE_USER: begin
              if (idx_q != 2'd0) begin
                sym_d = sh_q[7:6];
                sh_d  = {sh_q[5:0], 2'b00};
                idx_d = idx_q + 2'd1;
                live  = 1'b1;
              end else if (buf_vld_q) begin
                sym_d     = buf_q[7:6];
                sh_d      = {buf_q[5:0], 2'b00};
                idx_d     = 2'd1;
                buf_vld_d = 1'b0;
                live      = 1'b1;
              end else begin
                underrun_d = 1'b1;
              end
            end
            MODE_CLK: begin
              sym_d   = phase_q ? 2'b00 : 2'b10;
              phase_d = ~phase_q;
              live    = 1'b1;
            end
`ifdef PAM4_TX_PRBS_EN
            MODE_PRBS: begin
              sym_d = prbs_sym;
              live  = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        level_d = live ? gray_level(sym_d) : LVL_ZERO;
      end
      if (accept) begin
        buf_d     = s_data;
        buf_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      phase_q    <= 1'b0;
      idx_q      <= 2'd0;
      sh_q       <= 8'd0;
      buf_q      <= 8'd0;
      buf_vld_q  <= 1'b0;
      underrun_q <= 1'b0;
      level_q    <= LVL_ZERO;
      sym_q      <= 2'b00;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      underrun_q <= underrun_d;
      level_q    <= level_d;
      sym_q      <= sym_d;
      stb_q      <= stb_d;
    end
  end

  assign tx_level = level_q;
  assign sym      = sym_q;
  assign sym_stb  = stb_q;
  assign busy     = (state_q != ST_IDLE);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pam4_tx.sv
// Bench for pam4_tx: directed scenarios plus randomized traffic, checked against a symbol-stream
// reference model built from byte queues, a PRBS bit sequence and a baud-period count.
module tb_pam4_tx;

  localparam int         PLEN  = 4;
  localparam logic [7:0] L_N96 = 8'hA0;
  localparam logic [7:0] L_N32 = 8'hE0;
  localparam logic [7:0] L_P32 = 8'h20;
  localparam logic [7:0] L_P96 = 8'h60;
  localparam logic [7:0] L_0   = 8'h00;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [7:0]        baud_div;
  logic [1:0]        mode;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] tx_level;
  logic [1:0]        sym;
  logic              sym_stb;
  logic              busy;
  logic              underrun;

  pam4_tx #(.DIV_W(8), .PREAMBLE_LEN(PLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .baud_div (baud_div),
    .mode     (mode),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .tx_level (tx_level),
    .sym      (sym),
    .sym_stb  (sym_stb),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int         m_st;      // 0 idle, 1 preamble, 2 payload
  int         m_cnt;     // cycles since last strobe / enable
  int         m_pre;     // preamble symbols sent
  bit         m_phase;   // alternation: 0 -> next is +96
  int         m_idx;     // symbols of current byte already sent
  int         m_pk;      // PRBS bits consumed since reset
  bit         m_ur;
  logic [7:0] m_cur;
  logic [7:0] m_q[$];
  logic [7:0] e_lvl;
  logic [1:0] e_sym;
  logic       e_stb;
  bit         last_acc;
  bit         p[0:133];  // PRBS bits, p[k+7] is output bit k

  logic [7:0] got[$];
  logic [7:0] ev[$];

  function automatic logic [7:0] lvl_of(input logic [1:0] s);
    case (s)
      2'b00:   return L_N96;
      2'b01:   return L_N32;
      2'b11:   return L_P32;
      default: return L_P96;
    endcase
  endfunction

  function automatic bit prbs_bit(input int k);
    return p[(k % 127) + 7];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag);
    for (int i = 0; i < ev.size(); i++)
      chk(tag, (i < got.size()) ? got[i] : ~ev[i], ev[i]);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_pre = 0; m_phase = 1'b0; m_idx = 0; m_pk = 0; m_ur = 1'b0;
    m_cur = 8'd0; m_q.delete();
    e_lvl = L_0; e_sym = 2'b00; e_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_level", tx_level, L_0);
    chk("rst_sym", 8'(sym), 8'd0);
    chk("rst_sym_stb", 8'(sym_stb), 8'd0);
    chk("rst_s_ready", 8'(s_ready), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_underrun", 8'(underrun), 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check s_ready mid-cycle, advance the model, check registered outputs after the edge.
  task automatic cyc();
    bit   stb, load, acc;
    logic exp_rdy;
    @(negedge clk);
    stb     = en && (m_cnt >= int'(baud_div));
    load    = stb && (m_st == 2) && (mode == 2'd0) && (m_idx == 0) && (m_q.size() != 0);
    exp_rdy = en && ((m_q.size() == 0) || load);
    chk("s_ready", 8'(s_ready), 8'(exp_rdy));
    acc      = s_valid && exp_rdy;
    last_acc = acc;
    if (!en) begin
      m_st = 0; m_cnt = 0; m_pre = 0; m_phase = 1'b0; m_idx = 0; m_q.delete();
      e_lvl = L_0; e_sym = 2'b00; e_stb = 1'b0;
    end else begin
      e_stb = stb;
      m_cnt = stb ? 0 : m_cnt + 1;
      if (stb) begin
        if (m_st != 2) begin
          e_sym   = m_phase ? 2'b00 : 2'b10;
          e_lvl   = lvl_of(e_sym);
          m_phase = !m_phase;
          m_pre++;
          m_st = (m_pre >= PLEN) ? 2 : 1;
        end else begin
          e_sym = 2'b00;
          e_lvl = L_0;
          case (mode)
            2'd0: begin
              if (m_idx == 0 && m_q.size() == 0) m_ur = 1'b1;
              else begin
                if (m_idx == 0) m_cur = m_q.pop_front();
                e_sym = 2'(m_cur >> (6 - 2 * m_idx));
                e_lvl = lvl_of(e_sym);
                m_idx = (m_idx + 1) % 4;
              end
            end
`ifdef PAM4_TX_PRBS_EN
            2'd1: begin
              e_sym = {prbs_bit(m_pk), prbs_bit(m_pk + 1)};
              e_lvl = lvl_of(e_sym);
              m_pk += 2;
            end
`endif
            2'd2: begin
              e_sym   = m_phase ? 2'b00 : 2'b10;
              e_lvl   = lvl_of(e_sym);
              m_phase = !m_phase;
            end
            default: ;
          endcase
          if (mode != 2'd0) m_idx = 0;
        end
      end
      if (acc) m_q.push_back(s_data);
    end
    @(posedge clk);
    #1;
    chk("tx_level", tx_level, e_lvl);
    chk("sym", 8'(sym), 8'(e_sym));
    chk("sym_stb", 8'(sym_stb), 8'(e_stb));
    chk("busy", 8'(busy), 8'(m_st != 0));
    chk("underrun", 8'(underrun), 8'(m_ur));
    if (sym_stb) got.push_back(tx_level);
  endtask

  initial begin
    int first, nb, acc_at;
    for (int i = 0; i < 7; i++) p[i] = 1'b1;
    for (int i = 7; i < 134; i++) p[i] = p[i - 7] ^ p[i - 6];

    rst = 1'b0; en = 1'b0; baud_div = 8'd0; mode = 2'd0; s_data = 8'd0; s_valid = 1'b0;
    #2;
    do_reset();

    // preamble then clock pattern, continuing phase
    mode = 2'd2; en = 1'b1; got.delete();
    repeat (8) cyc();
    ev = '{L_P96, L_N96, L_P96, L_N96, L_P96, L_N96, L_P96, L_N96};
    chk_seq("preamble_clock");
    en = 1'b0;
    cyc();
    chk("disabled_busy", 8'(busy), 8'd0);

    // PRBS7 right after reset seed
    mode = 2'd1; en = 1'b1; got.delete();
    repeat (8) cyc();
`ifdef PAM4_TX_PRBS_EN
    ev = '{L_P96, L_N96, L_P96, L_N96, L_N96, L_N96, L_N96, L_P96};
`else
    ev = '{L_P96, L_N96, L_P96, L_N96, L_0, L_0, L_0, L_0};
`endif
    chk_seq("prbs_payload");
    en = 1'b0;
    cyc();

    // single user byte followed by underrun
    mode = 2'd0; en = 1'b1; s_data = 8'hB4; s_valid = 1'b1; got.delete();
    cyc();
    s_valid = 1'b0;
    repeat (8) cyc();
    ev = '{L_P96, L_N96, L_P96, L_N96, L_P96, L_P32, L_N32, L_N96, L_0};
    chk_seq("user_b4");
    repeat (3) cyc();
    chk("underrun_sticky", 8'(underrun), 8'd1);
    en = 1'b0;
    cyc();

    // back-to-back bytes with s_valid held
    en = 1'b1; s_data = 8'h1B; s_valid = 1'b1; got.delete(); nb = 0; acc_at = 0;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (last_acc) begin
        if (nb == 1) acc_at = c;
        if (nb == 0) s_data = 8'hE4;
        else s_valid = 1'b0;
        nb++;
      end
    end
    chk("second_byte_accept_cycle", 8'(acc_at), 8'd5);
    ev = '{L_P96, L_N96, L_P96, L_N96, L_N96, L_N32, L_P96, L_P32, L_P32, L_P96, L_N32, L_N96};
    chk_seq("back_to_back");
    en = 1'b0;
    cyc();

    // enable dropped mid-byte, then a fresh preamble
    en = 1'b1; s_data = 8'h5A; s_valid = 1'b1;
    cyc();
    s_valid = 1'b0;
    repeat (5) cyc();
    en = 1'b0;
    #1;
    chk("drop_s_ready", 8'(s_ready), 8'd0);
    cyc();
    chk("drop_tx_level", tx_level, L_0);
    chk("drop_busy", 8'(busy), 8'd0);
    en = 1'b1; got.delete();
    repeat (4) cyc();
    ev = '{L_P96, L_N96, L_P96, L_N96};
    chk_seq("re_preamble");

    // reset in the middle of payload, restart at baud_div=3
    mode = 2'd2;
    repeat (3) cyc();
    baud_div = 8'd3;
    do_reset();
    got.delete(); first = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (sym_stb && first == 0) first = k;
    end
    chk("first_stb_delay", 8'(first), 8'd4);
    ev = '{L_P96};
    chk_seq("first_stb_level");

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if (en ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0)) en = ~en;
      if ($urandom_range(0, 24) == 0) baud_div = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) mode = 2'($urandom_range(0, 3));
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
